// File: rtl/arith_pkg.sv
// Shared definitions for the serial adder/subtractor: FSM encoding and a
// width helper for the digit counter.
package arith_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bits needed to count n values, never less than one.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/add_digit.sv
// DIGIT-bit ripple adder slice made of one-bit full-adder cells. Also exposes
// the carry entering the slice MSB so the caller can form signed overflow.
module add_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             c_in,
    output logic [DIGIT-1:0] s_d,
    output logic             c_out,
    output logic             c_msb_in
);

    logic w_c;

    // Ripple the carry through one full-adder cell per bit, LSB first.
    always_comb begin
        w_c      = c_in;
        s_d      = '0;
        c_msb_in = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                c_msb_in = w_c;
            end
            s_d[i] = a_d[i] ^ b_d[i] ^ w_c;
            w_c    = (a_d[i] & b_d[i]) | (w_c & (a_d[i] ^ b_d[i]));
        end
        c_out = w_c;
    end

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are consumed DIGIT bits per
// clock through a registered carry. Start/done handshake, carry-out and
// two's-complement overflow reported with the result.
module serial_add_sub
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = clog2(N);

    state_t           r_state;
    state_t           w_next;
    // r_a doubles as the result register: each processed digit leaves the
    // bottom and its sum digit enters at the top, so after N steps it holds
    // the full result.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_done;

    logic [DIGIT-1:0] w_s_d;
    logic             w_c_out;
    logic             w_c_msb_in;
    logic             w_last;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;

    add_digit #(.DIGIT(DIGIT)) u_digit (
        .a_d      (r_a[DIGIT-1:0]),
        .b_d      (r_b[DIGIT-1:0]),
        .c_in     (r_carry),
        .s_d      (w_s_d),
        .c_out    (w_c_out),
        .c_msb_in (w_c_msb_in)
    );

    assign w_last = (r_cnt == CW'(N - 1));

    if (DIGIT == WIDTH) begin : g_full
        assign w_a_next = w_s_d;
        assign w_b_next = '0;
    end else begin : g_part
        assign w_a_next = {w_s_d, r_a[WIDTH-1:DIGIT]};
        assign w_b_next = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: accept start when idle, return to idle after the last digit.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_next = RUN;
            RUN:     if (w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        ready = (r_state == IDLE);
        busy  = (r_state == RUN);
    end

    // Operand capture, per-digit shift/carry update and result load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (start) begin
                    // Subtraction is a + ~b + ~cin, so borrow-in becomes ~cin.
                    r_a     <= a;
                    r_b     <= sub ? ~b : b;
                    r_carry <= sub ? ~cin : cin;
                    r_cnt   <= '0;
                end
            end else begin
                r_a     <= w_a_next;
                r_b     <= w_b_next;
                r_carry <= w_c_out;
                r_cnt   <= r_cnt + CW'(1);
                if (w_last) begin
                    r_sum  <= w_a_next;
                    r_cout <= w_c_out;
                    r_ovf  <= w_c_out ^ w_c_msb_in;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub at DIGIT = 1, 4 and 8 (WIDTH = 8).
module tb_serial_add_sub;

    logic       clk;
    logic       rst;
    logic [2:0] st;
    logic       sub;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;

    logic [2:0] w_ready;
    logic [2:0] w_busy;
    logic [2:0] w_done;
    logic [2:0] w_cout;
    logic [2:0] w_ovf;
    logic [7:0] w_sum [3];

    int n_tests = 0;
    int n_fail  = 0;
    int nd;

    serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(st[0]), .sub(sub), .cin(cin), .a(a), .b(b),
        .ready(w_ready[0]), .busy(w_busy[0]), .done(w_done[0]), .sum(w_sum[0]),
        .cout(w_cout[0]), .overflow(w_ovf[0])
    );

    serial_add_sub #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(st[1]), .sub(sub), .cin(cin), .a(a), .b(b),
        .ready(w_ready[1]), .busy(w_busy[1]), .done(w_done[1]), .sum(w_sum[1]),
        .cout(w_cout[1]), .overflow(w_ovf[1])
    );

    serial_add_sub #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst(rst), .start(st[2]), .sub(sub), .cin(cin), .a(a), .b(b),
        .ready(w_ready[2]), .busy(w_busy[2]), .done(w_done[2]), .sum(w_sum[2]),
        .cout(w_cout[2]), .overflow(w_ovf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; start is seen by the next posedge and the task
    // returns at the negedge just after that acceptance edge.
    task automatic issue(input int idx, input logic s, input logic c,
                         input logic [7:0] aa, input logic [7:0] bb);
        a       = aa;
        b       = bb;
        sub     = s;
        cin     = c;
        st[idx] = 1'b1;
        @(negedge clk);
        st[idx] = 1'b0;
    endtask

    // Waits (bounded) for done, checking busy/ready and a stable sum meanwhile,
    // then checks latency in cycles and the result.
    task automatic collect(input int idx, input string tag, input int exp_lat,
                           input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        int bad;
        logic [7:0] held;
        lat  = 0;
        bad  = 0;
        held = w_sum[idx];
        while (w_done[idx] !== 1'b1 && lat < 20) begin
            if (w_busy[idx] !== 1'b1 || w_ready[idx] !== 1'b0 || w_sum[idx] !== held)
                bad++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"},   32'(lat), 32'(exp_lat));
        check({tag, "_run"},   32'(bad), 32'd0);
        check({tag, "_sum"},   32'(w_sum[idx]), 32'(es));
        check({tag, "_cout"},  32'(w_cout[idx]), 32'(ec));
        check({tag, "_ovf"},   32'(w_ovf[idx]), 32'(eo));
        check({tag, "_ready"}, 32'(w_ready[idx]), 32'd1);
        check({tag, "_busy"},  32'(w_busy[idx]), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        st  = '0;
        a   = '0;
        b   = '0;
        sub = 1'b0;
        cin = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_ready", 32'(w_ready[0]), 32'd1);
        check("rst_busy",  32'(w_busy[0]),  32'd0);
        check("rst_done",  32'(w_done[0]),  32'd0);
        check("rst_sum",   32'(w_sum[0]),   32'd0);
        check("rst_cout",  32'(w_cout[0]),  32'd0);
        check("rst_ovf",   32'(w_ovf[0]),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // DIGIT = 1 arithmetic vectors
        issue(0, 1'b0, 1'b0, 8'd200, 8'd100);
        collect(0, "add_200_100", 8, 8'd44, 1'b1, 1'b0);
        @(negedge clk);
        check("done_pulse", 32'(w_done[0]), 32'd0);

        issue(0, 1'b0, 1'b0, 8'd127, 8'd1);
        collect(0, "add_ovf", 8, 8'h80, 1'b0, 1'b1);
        // issued in the done cycle: back-to-back acceptance
        issue(0, 1'b0, 1'b1, 8'd255, 8'd0);
        collect(0, "add_wrap", 8, 8'h00, 1'b1, 1'b0);
        @(negedge clk);

        issue(0, 1'b1, 1'b0, 8'd5, 8'd7);
        collect(0, "sub_neg", 8, 8'hFE, 1'b0, 1'b0);
        issue(0, 1'b1, 1'b0, 8'h80, 8'd1);
        collect(0, "sub_ovf", 8, 8'h7F, 1'b1, 1'b1);
        issue(0, 1'b1, 1'b1, 8'd9, 8'd4);
        collect(0, "sub_bin", 8, 8'd4, 1'b1, 1'b0);
        @(negedge clk);

        // start while busy is ignored
        issue(0, 1'b0, 1'b0, 8'd10, 8'd20);
        @(negedge clk);
        a     = 8'd99;
        b     = 8'd99;
        sub   = 1'b1;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        collect(0, "ignore", 6, 8'd30, 1'b0, 1'b0);
        // back-to-back start in the done cycle
        issue(0, 1'b0, 1'b0, 8'd3, 8'd4);
        collect(0, "b2b", 8, 8'd7, 1'b0, 1'b0);
        @(negedge clk);

        // asynchronous reset in the middle of an operation
        issue(0, 1'b0, 1'b0, 8'd50, 8'd60);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", 32'(w_ready[0]), 32'd1);
        check("arst_busy",  32'(w_busy[0]),  32'd0);
        check("arst_sum",   32'(w_sum[0]),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        nd  = 0;
        repeat (12) begin
            @(negedge clk);
            if (w_done[0] !== 1'b0) nd++;
        end
        check("arst_nodone", 32'(nd), 32'd0);
        issue(0, 1'b0, 1'b0, 8'd1, 8'd2);
        collect(0, "post_rst", 8, 8'd3, 1'b0, 1'b0);
        @(negedge clk);

        // DIGIT = 4
        issue(1, 1'b0, 1'b0, 8'hF0, 8'h10);
        collect(1, "d4_add", 2, 8'h00, 1'b1, 1'b0);
        issue(1, 1'b0, 1'b0, 8'h0F, 8'h01);
        collect(1, "d4_cry", 2, 8'h10, 1'b0, 1'b0);
        issue(1, 1'b1, 1'b0, 8'h80, 8'h01);
        collect(1, "d4_sub", 2, 8'h7F, 1'b1, 1'b1);
        @(negedge clk);

        // DIGIT = 8
        issue(2, 1'b0, 1'b0, 8'hF0, 8'h10);
        collect(2, "d8_add", 1, 8'h00, 1'b1, 1'b0);
        issue(2, 1'b1, 1'b0, 8'h80, 8'h01);
        collect(2, "d8_sub", 1, 8'h7F, 1'b1, 1'b1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
